// File: rtl/pn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// pn_seq_ctrl
//   Sequencing controller for a variable-length PN (LFSR) generator.
//   Accepts a configuration, loads the generator through its seed path, then
//   steps it a programmed number of times. Each generator output bit is
//   delivered on a valid/ready serial stream.
//   Optional feature macro: PN_PERIOD_DETECT_EN (period measurement).
//   Revision: 1.0
// ============================================================================
module pn_seq_ctrl #(
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_n,
  input  logic [12:0]      cfg_poly,
  input  logic [7:0]       cfg_seed,
  input  logic [RUN_W-1:0] cfg_run,
  input  logic             abort,
  output logic             gen_reset,
  output logic             gen_next,
  output logic [3:0]       gen_n,
  output logic [12:0]      gen_poly,
  output logic [7:0]       gen_init,
  input  logic [12:0]      gen_seq,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [13:0]      period,
  output logic             period_valid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_HI = 3'd1;
  localparam logic [2:0] S_LOAD_LO = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_STEP_HI = 3'd4;
  localparam logic [2:0] S_STEP_LO = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] w_cnt_inc;
  logic [3:0]       gen_n_q;
  logic [12:0]      gen_poly_q;
  logic [7:0]       gen_init_q;
  logic             gen_reset_q, gen_next_q, bit_valid_q;
  logic             busy_q, done_q, cfg_err_q, cfg_ready_q;
  logic             w_accept, w_reject;
  logic [7:0]       w_seed_mask;
  logic             w_cfg_ok;

  // Only the low 8 bits of the length mask matter, since the seed is 8 bits.
  // Lengths of 8 and above wrap the 9-bit shift to an all-ones mask.
  assign w_seed_mask = 8'((9'd1 << cfg_n) - 9'd1);
  assign w_cfg_ok    = (cfg_n >= 4'd2) && (cfg_n <= 4'd13) &&
                       ((cfg_seed & w_seed_mask) != 8'd0);
  assign w_cnt_inc   = cnt_q + RUN_W'(1);

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (w_cfg_ok) begin
            w_accept = 1'b1;
            cnt_d    = '0;
            state_d  = S_LOAD_HI;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_LOAD_HI: state_d = S_LOAD_LO;
      S_LOAD_LO: state_d = (run_q == '0) ? S_DONE : S_EMIT;
      S_EMIT:    if (bit_ready) state_d = S_STEP_HI;
      S_STEP_HI: state_d = S_STEP_LO;
      S_STEP_LO: begin
        cnt_d   = w_cnt_inc;
        state_d = (w_cnt_inc == run_q) ? S_DONE : S_EMIT;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      w_accept = 1'b0;
      w_reject = 1'b0;
    end
  end

  // State, counters, latched configuration and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      run_q       <= '0;
      gen_n_q     <= '0;
      gen_poly_q  <= '0;
      gen_init_q  <= '0;
      gen_reset_q <= 1'b0;
      gen_next_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        run_q      <= cfg_run;
        gen_n_q    <= cfg_n;
        gen_poly_q <= cfg_poly;
        gen_init_q <= cfg_seed;
      end
      gen_reset_q <= (state_d == S_LOAD_HI);
      gen_next_q  <= (state_d == S_STEP_HI);
      bit_valid_q <= (state_d == S_EMIT);
      done_q      <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
      cfg_ready_q <= (state_d == S_IDLE);
      cfg_err_q   <= w_reject;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign gen_reset = gen_reset_q;
  assign gen_next  = gen_next_q;
  assign gen_n     = gen_n_q;
  assign gen_poly  = gen_poly_q;
  assign gen_init  = gen_init_q;
  // The generator is not stepped while in EMIT, so gen_seq[0] is stable there.
  assign bit_out   = bit_valid_q & gen_seq[0];
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

`ifdef PN_PERIOD_DETECT_EN
  localparam int CW = (RUN_W > 14) ? RUN_W : 14;

  logic          cmp_pend_q;
  logic [13:0]   period_q;
  logic          period_valid_q;
  logic [12:0]   w_gen_mask;
  logic [CW-1:0] w_cnt_ext;
  logic          w_match;

  assign w_gen_mask = 13'((14'd1 << gen_n_q) - 14'd1);
  assign w_cnt_ext  = CW'(cnt_q);
  assign w_match    = ((gen_seq & w_gen_mask) == ({5'd0, gen_init_q} & w_gen_mask));

  // Compare the generator state against the seed one cycle after each step
  // (when the stepped state is settled); latch the first match of the run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmp_pend_q     <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else if (abort || w_accept) begin
      cmp_pend_q     <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      cmp_pend_q <= (state_q == S_STEP_LO);
      if (cmp_pend_q && !period_valid_q && w_match) begin
        period_q       <= w_cnt_ext[13:0];
        period_valid_q <= 1'b1;
      end
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
`else
  logic w_unused_seq;
  assign w_unused_seq = ^gen_seq[12:1];
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pn_seq_ctrl
//   Self-checking bench for pn_seq_ctrl with a behavioural PN generator and
//   a transaction-level reference model of the expected bit stream, step
//   count, completion latency and period.
//   Revision: 1.0
// ============================================================================
module tb_pn_seq_ctrl;

  localparam int RUN_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [3:0]       cfg_n = '0;
  logic [12:0]      cfg_poly = '0;
  logic [7:0]       cfg_seed = '0;
  logic [RUN_W-1:0] cfg_run = '0;
  logic             abort = 1'b0;
  logic             gen_reset, gen_next;
  logic [3:0]       gen_n;
  logic [12:0]      gen_poly;
  logic [7:0]       gen_init;
  logic [12:0]      gen_seq;
  logic             bit_out, bit_valid;
  logic             bit_ready = 1'b1;
  logic             busy, done, cfg_err;
  logic [13:0]      period;
  logic             period_valid;

  int n_checks = 0;
  int n_fail   = 0;

  pn_seq_ctrl #(.RUN_W(RUN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_poly(cfg_poly), .cfg_seed(cfg_seed), .cfg_run(cfg_run),
    .abort(abort),
    .gen_reset(gen_reset), .gen_next(gen_next),
    .gen_n(gen_n), .gen_poly(gen_poly), .gen_init(gen_init), .gen_seq(gen_seq),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .period(period), .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  // One generator step: shift right, feedback parity of (state & poly) into bit N-1.
  function automatic int lfsr_step(input int s, input int n, input int poly);
    int fb;
    fb = 0;
    for (int i = 0; i < n; i++) fb = fb ^ (((s & poly) >> i) & 1);
    return ((s >> 1) | (fb << (n - 1))) & ((1 << n) - 1);
  endfunction

  // Behavioural generator: loads on gen_reset, steps on each gen_next rising edge.
  logic [12:0] g_state = '0;
  logic        g_prev_next = 1'b0;
  int          steps = 0;
  always @(negedge clk) begin
    if (gen_reset === 1'b1)
      g_state = 13'(int'(gen_init) & ((1 << int'(gen_n)) - 1));
    else if (gen_next === 1'b1 && g_prev_next !== 1'b1) begin
      g_state = 13'(lfsr_step(int'(g_state), int'(gen_n), int'(gen_poly)));
      steps   = steps + 1;
    end
    g_prev_next = gen_next;
  end
  assign gen_seq = g_state;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // rmode: 0 = ready always high, 1 = random ready, 2 = ready low 4 cycles on bit 1.
  // abort_at: abort right after that many bits were handed over (0 = never).
  task automatic run_cfg(input int n, input int poly, input int seed, input int run,
                         input int rmode, input int abort_at);
    int   mask, s, exp_p, emitted, cyc, base, stall;
    bit   legal, exp_pv, fin, prev_stall, first_seen, rdy;
    logic prev_out;
    logic exp_bits[$];
    mask  = (1 << n) - 1;
    legal = (n >= 2) && (n <= 13) && ((seed & mask & 8'hff) != 0);
    s = seed & mask; exp_pv = 0; exp_p = 0;
    if (legal) begin
      for (int k = 1; k <= run; k++) begin
        exp_bits.push_back(1'(s & 1));
        s = lfsr_step(s, n, poly);
        if (!exp_pv && s == (seed & mask)) begin exp_pv = 1; exp_p = k; end
      end
    end
`ifndef PN_PERIOD_DETECT_EN
    exp_pv = 0; exp_p = 0;
`endif
    cfg_n = n[3:0]; cfg_poly = poly[12:0]; cfg_seed = seed[7:0]; cfg_run = run[RUN_W-1:0];
    cfg_valid = 1'b1;
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    base = steps;
    if (!legal) begin
      chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
      chk("reject_quiet", {29'd0, busy, gen_reset, gen_next}, 32'd0);
      tick();
      chk("cfg_err_clear", {30'd0, cfg_err, busy}, 32'd0);
      chk("reject_steps", steps - base, 32'd0);
      return;
    end
    chk("load_hi", {29'd0, busy, gen_reset, cfg_err}, 32'b110);
    chk("gen_cfg", {7'd0, n[3:0], poly[12:0], seed[7:0]}, {7'd0, gen_n, gen_poly, gen_init});
    tick();
    chk("load_lo", 32'(gen_reset), 32'd0);
    emitted = 0; cyc = 2; fin = 0; prev_stall = 0; stall = 0; first_seen = 0; prev_out = 1'b0;
    while (!fin && cyc < 3000) begin
      tick();
      cyc++;
      if (prev_stall)
        chk("hold", {29'd0, bit_valid, bit_out, gen_next}, {29'd0, 1'b1, prev_out, 1'b0});
      prev_stall = 0;
      if (done) begin
        chk("n_bits", emitted, run);
        chk("n_steps", steps - base, run);
        if (rmode == 0) chk("done_latency", cyc, 3 + 3 * run);
        tick();
        chk("idle_after_done", {29'd0, done, cfg_ready, busy}, 32'b010);
        chk("period", {17'd0, period_valid, period}, {17'd0, exp_pv, exp_p[13:0]});
        fin = 1;
      end else if (bit_valid) begin
        if (!first_seen) begin
          chk("first_valid", cyc, 3);
          first_seen = 1;
        end
        case (rmode)
          0:       rdy = 1;
          1:       rdy = ($urandom_range(0, 2) != 0);
          default: begin
            rdy = !(emitted == 1 && stall < 4);
            if (!rdy) stall++;
          end
        endcase
        bit_ready  = rdy;
        prev_stall = !rdy;
        prev_out   = bit_out;
        if (rdy) begin
          if (emitted < exp_bits.size()) chk("bit", 32'(bit_out), 32'(exp_bits[emitted]));
          else chk("extra_bit", 32'd1, 32'd0);
          emitted++;
          if (abort_at != 0 && emitted == abort_at) begin
            tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_idle",
                {25'd0, busy, done, bit_valid, gen_next, gen_reset, period_valid, cfg_ready},
                32'd1);
            tick();
            chk("abort_no_done", {31'd0, done}, 32'd0);
            fin = 1;
          end
        end
      end
    end
    bit_ready = 1'b1;
    if (!fin) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, poly, seed, run, ab;
    // Reset
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_outs_a", {8'd0, cfg_ready, gen_reset, gen_next, gen_n, gen_poly, bit_out, bit_valid},
        32'd0);
    chk("rst_outs_b", {6'd0, gen_init, busy, done, cfg_err, period, period_valid}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready", {30'd0, cfg_ready, busy}, 32'b10);

    // Directed runs
    run_cfg(4, 13'h0003, 8'h01, 5, 0, 0);
    run_cfg(4, 13'h0003, 8'h01, 20, 0, 0);
    run_cfg(4, 13'h0003, 8'h01, 0, 0, 0);
    run_cfg(4, 13'h0003, 8'h01, 6, 2, 0);
    run_cfg(1, 13'h0003, 8'h01, 5, 0, 0);
    run_cfg(14, 13'h0003, 8'h01, 5, 0, 0);
    run_cfg(4, 13'h0003, 8'h10, 5, 0, 0);
    run_cfg(4, 13'h0003, 8'h01, 20, 0, 2);
    run_cfg(4, 13'h0003, 8'h01, 5, 0, 0);
    run_cfg(13, 13'h001B, 8'hA5, 12, 1, 0);

    // Reset in the middle of a run
    cfg_n = 4'd4; cfg_poly = 13'h0003; cfg_seed = 8'h01; cfg_run = 16'd20;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    tick();
    ab = steps;
    chk("midrst_outs_a", {8'd0, cfg_ready, gen_reset, gen_next, gen_n, gen_poly, bit_out, bit_valid},
        32'd0);
    chk("midrst_outs_b", {6'd0, gen_init, busy, done, cfg_err, period, period_valid}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    chk("midrst_no_step", steps - ab, 32'd0);
    tick();
    chk("midrst_ready", {30'd0, cfg_ready, busy}, 32'b10);

    // Randomized configurations with random backpressure and occasional aborts
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: n = 0;
          1: n = 1;
          2: n = 14;
          default: n = 15;
        endcase
      end else begin
        n = int'($urandom_range(2, 13));
      end
      poly = int'($urandom_range(0, 8191));
      seed = int'($urandom_range(0, 255));
      run  = int'($urandom_range(0, 30));
      ab   = (run > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, run)) : 0;
      repeat ($urandom_range(0, 2)) tick();
      run_cfg(n, poly, seed, run, 1, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pn_seq_ctrl.md
# pn_seq_ctrl

Sequencing controller for the variable-length PN (LFSR) generator. It accepts a configuration (length N, characteristic polynomial, seed) over a valid/ready handshake, loads the generator through its reset/seed path, then steps it a programmed number of times. Each outgoing bit is delivered on a valid/ready serial stream. It sits between the control/register side and the PN generator and owns the generator's `next`/`reset` strobes exclusively.

## Interface
- `RUN_W`, default 16: width of the run-length counter.
- `clk` input 1: single clock; all logic on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `cfg_valid` input 1: configuration request.
- `cfg_ready` output 1: high only in IDLE.
- `cfg_n` input 4: sequence length N; legal 2..13.
- `cfg_poly` input 13: characteristic polynomial mask.
- `cfg_seed` input 8: initial state.
- `cfg_run` input RUN_W: number of bits to emit.
- `abort` input 1: synchronous abort, any state.
- `gen_reset` output 1: generator load strobe (registered).
- `gen_next` output 1: generator step strobe (registered).
- `gen_n` output 4, `gen_poly` output 13, `gen_init` output 8: latched configuration driven to the generator.
- `gen_seq` input 13: generator state.
- `bit_out` output 1, `bit_valid` output 1, `bit_ready` input 1: serial output stream.
- `busy` output 1: state not IDLE.
- `done` output 1: one-cycle pulse at run completion.
- `cfg_err` output 1: one-cycle pulse when a configuration is rejected.
- `period` output 14, `period_valid` output 1: measured period (see Configuration).

## Operation
- States: IDLE, LOAD_HI, LOAD_LO, EMIT, STEP_HI, STEP_LO, DONE.
- IDLE: when `cfg_valid` is high, the request is accepted. mask = (1<<cfg_n)-1.
  - Reject if cfg_n<2, cfg_n>13, or (cfg_seed & mask[7:0])==0. Rejection pulses `cfg_err` next cycle and stays in IDLE.
  - Otherwise latch cfg_n, cfg_poly, cfg_seed and cfg_run into the gen_* registers and go to LOAD_HI.
- LOAD_HI: `gen_reset`=1. LOAD_LO: `gen_reset`=0. Then go to EMIT, or to DONE if run==0.
- EMIT: `bit_out`=gen_seq[0], `bit_valid`=1, both held stable until `bit_ready`. On handshake go to STEP_HI.
- STEP_HI: `gen_next`=1. STEP_LO: `gen_next`=0.
  - Increment the emitted count.
  - If count==run, go to DONE; else go to EMIT.
- DONE: `done`=1 for one cycle, then IDLE.
- Generator contract: on a `gen_next` rising edge, state shifts right and bit N-1 = XOR(gen_seq & gen_poly). On `gen_reset`, state = gen_init. `gen_seq` is valid in the cycle after the strobe falls.
- `abort`: next state is IDLE. `gen_next`, `gen_reset`, `bit_valid`, `done` and `period_valid` go to 0. No `done` pulse. Priority: `reset_n` > `abort` > FSM.
- A `cfg_valid` held while busy is ignored until IDLE.

## Timing
- Reset (`reset_n`=0 at an edge) clears every output to 0 and the state to IDLE. `cfg_ready`=1 from the first cycle after reset release.
- Handshake in cycle t: `gen_reset` high in t+1, low in t+2. First `bit_valid` in t+3.
- Per bit, with `bit_ready` held high: 3 cycles (EMIT, STEP_HI, STEP_LO). Steady throughput is 1 bit / 3 clk.
- Last step: STEP_LO → DONE. `done` is asserted the cycle after the last STEP_LO. `cfg_ready` is 1 the cycle after `done`.
- Counter width RUN_W with no wrap: run ≤ 2^RUN_W−1. The count compare is exact.
- `bit_valid` never drops without a handshake, except on `abort` or reset.

## Configuration
- `PN_PERIOD_DETECT_EN` defined:
  - After each STEP_LO, compare (gen_seq & mask) against (seed & mask).
  - On the first match of a run, latch `period` = steps taken so far and set `period_valid`=1.
  - Both stay set until the next accepted configuration, `abort` or reset. Later matches are ignored. The run continues to `cfg_run`.
- Not defined: no comparator or counter is built. `period`=0 and `period_valid`=0 permanently.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles mid-run → all outputs 0, `cfg_ready`=1 after release, no `gen_next` edge.
- N=4, poly=13'h0003, seed=8'h01, run=5 → `gen_reset` at t+1. `bit_out` stream 1,0,0,0,1. Exactly 5 `gen_next` pulses. `done` one cycle after the 5th STEP_LO.
- Same config, run=20, macro on → `period_valid` rises after step 15 with `period`=15. 20 bits emitted.
- Backpressure: `bit_ready` low for 4 cycles during EMIT → `bit_valid` and `bit_out` held stable, no `gen_next`.
- Invalid configs: cfg_n=1, cfg_n=14, and seed=8'h10 with N=4 → each gives one `cfg_err` pulse, `busy` stays 0, no strobes.
- Abort after the 2nd bit → next cycle IDLE, `done` stays 0, `period_valid` 0. A new config is accepted and restarts from the seed.
